// File: rtl/triangle_sequencer_if.sv
// Signal bundle between triangle_sequencer, its requester, drawline and vga_adapter.
// master = sequencer side, slave = environment side (requester, drawline, adapter).
interface triangle_sequencer_if;
  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
  localparam int unsigned CW = 3;

  logic          start;
  logic          done;
  logic [CW-1:0] colour;
  logic [XW-1:0] x0, x1, x2;
  logic [YW-1:0] y0, y1, y2;

  logic          dl_start;
  logic          dl_done;
  logic [XW-1:0] dl_x0, dl_x1;
  logic [YW-1:0] dl_y0, dl_y1;
  logic [CW-1:0] dl_colour;

  logic [XW-1:0] dl_vga_x;
  logic [YW-1:0] dl_vga_y;
  logic [CW-1:0] dl_vga_colour;
  logic          dl_vga_plot;

  logic [XW-1:0] vga_x;
  logic [YW-1:0] vga_y;
  logic [CW-1:0] vga_colour;
  logic          vga_plot;

  modport master (
    input  start, colour, x0, x1, x2, y0, y1, y2,
    input  dl_done, dl_vga_x, dl_vga_y, dl_vga_colour, dl_vga_plot,
    output done, dl_start, dl_x0, dl_x1, dl_y0, dl_y1, dl_colour,
    output vga_x, vga_y, vga_colour, vga_plot
  );

  modport slave (
    output start, colour, x0, x1, x2, y0, y1, y2,
    output dl_done, dl_vga_x, dl_vga_y, dl_vga_colour, dl_vga_plot,
    input  done, dl_start, dl_x0, dl_x1, dl_y0, dl_y1, dl_colour,
    input  vga_x, vga_y, vga_colour, vga_plot
  );
endinterface

// File: rtl/triangle_sequencer.sv
// Drives drawline over the three edges of a latched triangle and muxes the VGA pixel stream.
// Optional full-screen clear pass before the edges: define TRIANGLE_SEQUENCER_CLEAR_EN.
module triangle_sequencer #(
  parameter int unsigned SCR_W = 160,
  parameter int unsigned SCR_H = 120
) (
  input  logic                  clk,
  input  logic                  rst,
  triangle_sequencer_if.master  bus
);
  localparam int unsigned XW = 8;
  localparam int unsigned YW = 7;
  localparam int unsigned CW = 3;
  localparam int unsigned EW = 2;

  // Screen must be addressable by the coordinate buses.
  generate
    if (SCR_W == 0 || SCR_H == 0 || SCR_W > (1 << XW) || SCR_H > (1 << YW)) begin : g_bad_size
      $error("triangle_sequencer: SCR_W/SCR_H do not fit the coordinate widths");
    end
  endgenerate

`ifdef TRIANGLE_SEQUENCER_CLEAR_EN
  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_EDGE_GO, S_EDGE_WAIT, S_EDGE_REL, S_FIN
  } state_t;
  localparam logic [XW-1:0] CX_LAST = XW'(SCR_W - 1);
  localparam logic [YW-1:0] CY_LAST = YW'(SCR_H - 1);
  logic [XW-1:0] cx_q, cx_d;
  logic [YW-1:0] cy_q, cy_d;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_EDGE_GO, S_EDGE_WAIT, S_EDGE_REL, S_FIN
  } state_t;
`endif

  state_t        state_q, state_d;
  logic [EW-1:0] edge_q, edge_d;
  logic [XW-1:0] vx0_q, vx1_q, vx2_q, vx0_d, vx1_d, vx2_d;
  logic [YW-1:0] vy0_q, vy1_q, vy2_q, vy0_d, vy1_d, vy2_d;
  logic [CW-1:0] vcol_q, vcol_d;
  logic          done_q, done_d;
  logic          dl_start_q, dl_start_d;
  logic [XW-1:0] ax_q, bx_q, ax_d, bx_d;
  logic [YW-1:0] ay_q, by_q, ay_d, by_d;
  logic [CW-1:0] dcol_q, dcol_d;

  // State and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      edge_q     <= '0;
      vx0_q      <= '0;
      vx1_q      <= '0;
      vx2_q      <= '0;
      vy0_q      <= '0;
      vy1_q      <= '0;
      vy2_q      <= '0;
      vcol_q     <= '0;
      done_q     <= 1'b0;
      dl_start_q <= 1'b0;
      ax_q       <= '0;
      ay_q       <= '0;
      bx_q       <= '0;
      by_q       <= '0;
      dcol_q     <= '0;
`ifdef TRIANGLE_SEQUENCER_CLEAR_EN
      cx_q       <= '0;
      cy_q       <= '0;
`endif
    end else begin
      state_q    <= state_d;
      edge_q     <= edge_d;
      vx0_q      <= vx0_d;
      vx1_q      <= vx1_d;
      vx2_q      <= vx2_d;
      vy0_q      <= vy0_d;
      vy1_q      <= vy1_d;
      vy2_q      <= vy2_d;
      vcol_q     <= vcol_d;
      done_q     <= done_d;
      dl_start_q <= dl_start_d;
      ax_q       <= ax_d;
      ay_q       <= ay_d;
      bx_q       <= bx_d;
      by_q       <= by_d;
      dcol_q     <= dcol_d;
`ifdef TRIANGLE_SEQUENCER_CLEAR_EN
      cx_q       <= cx_d;
      cy_q       <= cy_d;
`endif
    end
  end

  // Next state and next register values.
  always_comb begin
    state_d    = state_q;
    edge_d     = edge_q;
    vx0_d      = vx0_q;
    vx1_d      = vx1_q;
    vx2_d      = vx2_q;
    vy0_d      = vy0_q;
    vy1_d      = vy1_q;
    vy2_d      = vy2_q;
    vcol_d     = vcol_q;
    done_d     = done_q;
    dl_start_d = dl_start_q;
    ax_d       = ax_q;
    ay_d       = ay_q;
    bx_d       = bx_q;
    by_d       = by_q;
    dcol_d     = dcol_q;
`ifdef TRIANGLE_SEQUENCER_CLEAR_EN
    cx_d       = cx_q;
    cy_d       = cy_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          vx0_d  = bus.x0;
          vx1_d  = bus.x1;
          vx2_d  = bus.x2;
          vy0_d  = bus.y0;
          vy1_d  = bus.y1;
          vy2_d  = bus.y2;
          vcol_d = bus.colour;
          edge_d = '0;
`ifdef TRIANGLE_SEQUENCER_CLEAR_EN
          cx_d    = '0;
          cy_d    = '0;
          state_d = S_CLEAR;
`else
          state_d = S_EDGE_GO;
`endif
        end
      end

`ifdef TRIANGLE_SEQUENCER_CLEAR_EN
      // Raster scan, x fastest; leaves after the bottom-right pixel.
      S_CLEAR: begin
        if (cx_q == CX_LAST) begin
          cx_d = '0;
          if (cy_q == CY_LAST) begin
            cy_d    = '0;
            state_d = S_EDGE_GO;
          end else begin
            cy_d = cy_q + YW'(1);
          end
        end else begin
          cx_d = cx_q + XW'(1);
        end
      end
`endif

      // Endpoints are registered together with dl_start, so they are valid as it rises.
      S_EDGE_GO: begin
        unique case (edge_q)
          2'd0: begin
            ax_d = vx0_q; ay_d = vy0_q; bx_d = vx1_q; by_d = vy1_q;
          end
          2'd1: begin
            ax_d = vx1_q; ay_d = vy1_q; bx_d = vx2_q; by_d = vy2_q;
          end
          default: begin
            ax_d = vx2_q; ay_d = vy2_q; bx_d = vx0_q; by_d = vy0_q;
          end
        endcase
        dcol_d     = vcol_q;
        dl_start_d = 1'b1;
        state_d    = S_EDGE_WAIT;
      end

      S_EDGE_WAIT: begin
        if (bus.dl_done) begin
          dl_start_d = 1'b0;
          state_d    = S_EDGE_REL;
        end
      end

      // Wait for drawline to drop done so a stale done cannot satisfy the next edge.
      S_EDGE_REL: begin
        if (!bus.dl_done) begin
          if (edge_q == 2'd2) begin
            done_d  = 1'b1;
            state_d = S_FIN;
          end else begin
            edge_d  = edge_q + EW'(1);
            state_d = S_EDGE_GO;
          end
        end
      end

      S_FIN: begin
        if (!bus.start) begin
          done_d  = 1'b0;
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.done      = done_q;
  assign bus.dl_start  = dl_start_q;
  assign bus.dl_x0     = ax_q;
  assign bus.dl_y0     = ay_q;
  assign bus.dl_x1     = bx_q;
  assign bus.dl_y1     = by_q;
  assign bus.dl_colour = dcol_q;

  // Pixel stream mux; zero-latency pass-through of drawline outside the clear pass.
  always_comb begin
    bus.vga_x      = bus.dl_vga_x;
    bus.vga_y      = bus.dl_vga_y;
    bus.vga_colour = bus.dl_vga_colour;
    bus.vga_plot   = bus.dl_vga_plot & ~rst;
`ifdef TRIANGLE_SEQUENCER_CLEAR_EN
    if (state_q == S_CLEAR) begin
      bus.vga_x      = cx_q;
      bus.vga_y      = cy_q;
      bus.vga_colour = '0;
      bus.vga_plot   = ~rst;
    end
`endif
  end

endmodule

// File: tb/tb_triangle_sequencer.sv
// Directed bench for triangle_sequencer with a behavioural drawline handshake model.
// Clear-pass checks are compiled only when TRIANGLE_SEQUENCER_CLEAR_EN is defined.
module tb_triangle_sequencer;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  triangle_sequencer_if bus ();

  triangle_sequencer #(.SCR_W(160), .SCR_H(120)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int passed = 0;
  int fails  = 0;
  int total  = 0;

  // drawline model state and edge log
  int lat  = 5;
  int hold = 0;
  int nst = 0, viol = 0, ncyc = 0, fall_cyc = 0, lat_cnt = 0, hold_cnt = 0;
  logic prev_start = 1'b0;
  logic [7:0] rx0 [64];
  logic [7:0] rx1 [64];
  logic [6:0] ry0 [64];
  logic [6:0] ry1 [64];
  logic [2:0] rcol [64];
  int gap [64];

  // clear-pass tracking
  int plot_run = 0, plot_bad = 0, plot_first_cyc = 0, plot_last_cyc = 0, plot_at_rise = -1;
  logic [7:0] fx = '0, lx = '0;
  logic [6:0] fy = '0, ly = '0;

  always @(negedge clk) begin
    if (rst) begin
      bus.dl_done = 1'b0;
      lat_cnt     = 0;
      hold_cnt    = 0;
      prev_start  = 1'b0;
    end else begin
      ncyc++;
      if (bus.vga_plot) begin
        if (plot_run == 0) begin
          fx = bus.vga_x; fy = bus.vga_y; plot_first_cyc = ncyc;
        end
        if (bus.vga_colour != 3'd0) plot_bad++;
        plot_run++;
        lx = bus.vga_x; ly = bus.vga_y; plot_last_cyc = ncyc;
      end
      if (bus.dl_start && !prev_start) begin
        if (bus.dl_done) viol++;
        if (nst == 0) plot_at_rise = plot_run;
        rx0[nst]  = bus.dl_x0;
        ry0[nst]  = bus.dl_y0;
        rx1[nst]  = bus.dl_x1;
        ry1[nst]  = bus.dl_y1;
        rcol[nst] = bus.dl_colour;
        gap[nst]  = ncyc - fall_cyc;
        nst++;
      end
      prev_start = bus.dl_start;
      if (bus.dl_start && !bus.dl_done) begin
        lat_cnt++;
        if (lat_cnt >= lat) begin
          bus.dl_done = 1'b1;
          lat_cnt     = 0;
        end
      end else if (!bus.dl_start && bus.dl_done) begin
        if (hold_cnt >= hold) begin
          bus.dl_done = 1'b0;
          hold_cnt    = 0;
          fall_cyc    = ncyc;
        end else begin
          hold_cnt++;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_edge(input int k, input int ax, input int ay, input int bx, input int by,
                          input int col);
    check($sformatf("edge%0d_x0", k), 32'(rx0[k]), ax);
    check($sformatf("edge%0d_y0", k), 32'(ry0[k]), ay);
    check($sformatf("edge%0d_x1", k), 32'(rx1[k]), bx);
    check($sformatf("edge%0d_y1", k), 32'(ry1[k]), by);
    check($sformatf("edge%0d_col", k), 32'(rcol[k]), col);
  endtask

  task automatic set_tri(input int ax, input int ay, input int bx, input int by,
                         input int cx, input int cy, input int col);
    bus.x0 = 8'(ax); bus.y0 = 7'(ay);
    bus.x1 = 8'(bx); bus.y1 = 7'(by);
    bus.x2 = 8'(cx); bus.y2 = 7'(cy);
    bus.colour = 3'(col);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 30000 && !bus.done; i++) @(negedge clk);
    check("done_seen", 32'(bus.done), 1);
  endtask

  initial begin
    int base;
    rst = 1'b1;
    bus.start = 1'b1;
    bus.dl_vga_x = '0;
    bus.dl_vga_y = '0;
    bus.dl_vga_colour = '0;
    bus.dl_vga_plot = 1'b0;
    set_tri(80, 90, 60, 65, 100, 65, 3'b100);
    repeat (3) @(negedge clk);
    check("rst_done", 32'(bus.done), 0);
    check("rst_dl_start", 32'(bus.dl_start), 0);
    check("rst_dl_x0", 32'(bus.dl_x0), 0);
    check("rst_dl_colour", 32'(bus.dl_colour), 0);
    check("rst_vga_plot", 32'(bus.vga_plot), 0);

    // Triangle 1: start held through reset release
    base = nst;
    rst = 1'b0;
    wait_done();
    check("t1_edges", 32'(nst - base), 3);
    chk_edge(base + 0, 80, 90, 60, 65, 4);
    chk_edge(base + 1, 60, 65, 100, 65, 4);
    chk_edge(base + 2, 100, 65, 80, 90, 4);
    check("t1_stale_done_starts", 32'(viol), 0);
`ifdef TRIANGLE_SEQUENCER_CLEAR_EN
    check("clr_plots_before_edge0", 32'(plot_at_rise), 19200);
    check("clr_contiguous", 32'(plot_last_cyc - plot_first_cyc + 1), 19200);
    check("clr_bad_colour", 32'(plot_bad), 0);
    check("clr_first_x", 32'(fx), 0);
    check("clr_first_y", 32'(fy), 0);
    check("clr_last_x", 32'(lx), 159);
    check("clr_last_y", 32'(ly), 119);
`endif

    // start held in FIN must not retrigger
    repeat (50) @(negedge clk);
    check("hold_no_retrigger", 32'(nst - base), 3);
    check("hold_done_high", 32'(bus.done), 1);
    bus.start = 1'b0;
    @(negedge clk);
    check("done_drop", 32'(bus.done), 0);

    // Triangle 2: drawline keeps done high after dl_start falls
    hold = 4;
    base = nst;
    set_tri(10, 20, 30, 40, 50, 60, 3'b011);
    bus.start = 1'b1;
    wait_done();
    check("t2_edges", 32'(nst - base), 3);
    chk_edge(base + 0, 10, 20, 30, 40, 3);
    chk_edge(base + 1, 30, 40, 50, 60, 3);
    chk_edge(base + 2, 50, 60, 10, 20, 3);
    check("t2_gap_edge1", 32'(gap[base + 1]), 2);
    check("t2_gap_edge2", 32'(gap[base + 2]), 2);
    check("t2_stale_done_starts", 32'(viol), 0);
    bus.start = 1'b0;
    @(negedge clk);
    hold = 0;

    // Reset during edge1 wait
    base = nst;
    set_tri(1, 2, 3, 4, 5, 6, 3'b001);
    bus.start = 1'b1;
    for (int i = 0; i < 30000 && nst < base + 2; i++) @(negedge clk);
    check("rs_edge1_started", 32'(nst - base), 2);
    check("rs_in_wait", 32'(bus.dl_start), 1);
    bus.dl_vga_plot = 1'b1;
    rst = 1'b1;
    #1;
    check("rs_done", 32'(bus.done), 0);
    check("rs_dl_start", 32'(bus.dl_start), 0);
    check("rs_vga_plot", 32'(bus.vga_plot), 0);
    check("rs_dl_x0", 32'(bus.dl_x0), 0);
    @(negedge clk);
    bus.start = 1'b0;
    bus.dl_vga_plot = 1'b0;
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("rs_idle_no_start", 32'(nst - base), 2);
    check("rs_idle_dl_start", 32'(bus.dl_start), 0);
    check("rs_idle_done", 32'(bus.done), 0);

    // Degenerate triangle: all vertices coincide
    base = nst;
    set_tri(5, 5, 5, 5, 5, 5, 3'b010);
    bus.start = 1'b1;
    wait_done();
    check("dg_edges", 32'(nst - base), 3);
    chk_edge(base + 0, 5, 5, 5, 5, 2);
    chk_edge(base + 1, 5, 5, 5, 5, 2);
    chk_edge(base + 2, 5, 5, 5, 5, 2);
    bus.start = 1'b0;
    @(negedge clk);
    check("dg_done_drop", 32'(bus.done), 0);

    // VGA pass-through in IDLE
    bus.dl_vga_x = 8'd123;
    bus.dl_vga_y = 7'd45;
    bus.dl_vga_colour = 3'd5;
    bus.dl_vga_plot = 1'b1;
    #1;
    check("pt_x", 32'(bus.vga_x), 123);
    check("pt_y", 32'(bus.vga_y), 45);
    check("pt_colour", 32'(bus.vga_colour), 5);
    check("pt_plot", 32'(bus.vga_plot), 1);
    bus.dl_vga_plot = 1'b0;
    #1;
    check("pt_plot_low", 32'(bus.vga_plot), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
